// File: rtl/sonic_ranger_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sonic_pkg
// Shared definitions for the ultrasonic ranger sequencer and its measurer:
//   - default cycle constants (50 MHz system clock)
//   - FSM state encoding
//   - error codes reported on err_code
//   - a small helper used to size the shared down-counter
// ---------------------------------------------------------------------------
package sonic_pkg;

  localparam int DEF_DIST_W      = 17;
  localparam int DEF_TRIG_CYC    = 500;
  localparam int DEF_ARM_TO_CYC  = 50_000;
  localparam int DEF_MEAS_TO_CYC = 140_000;
  localparam int DEF_GAP_CYC     = 2_500_000;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ARM,
    WAIT_MEAS,
    GAP
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ARM  = 2'b01;
  localparam logic [1:0] ERR_MEAS = 2'b10;

  // Largest of the cycle constants; the shared timer must hold any of them.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sonic_ranger_ctrl_if.sv
// ---------------------------------------------------------------------------
// sonic_ranger_ctrl_if
// Bundles the sequencer <-> measurer link and the result outputs.
//   trigger    sequencer -> sensor/measurer trigger
//   trig_suc   measurer  -> 1-cycle pulse, echo rise seen
//   meas_valid measurer  -> 1-cycle pulse, echo fall seen
//   meas_dist  measurer  -> echo width in cycles, valid with meas_valid
//   dist_out   last good distance (held)
//   dist_valid 1-cycle pulse, dist_out updated
//   err        1-cycle pulse, shot failed
//   err_code   01 arm timeout, 10 measure timeout (held)
// master: the sequencer side; slave: the measurer / consumer side.
// ---------------------------------------------------------------------------
interface sonic_ranger_ctrl_if #(
  parameter int DIST_W = sonic_pkg::DEF_DIST_W
) ();

  logic              trigger;
  logic              trig_suc;
  logic              meas_valid;
  logic [DIST_W-1:0] meas_dist;
  logic [DIST_W-1:0] dist_out;
  logic              dist_valid;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output trigger, dist_out, dist_valid, err, err_code,
    input  trig_suc, meas_valid, meas_dist
  );

  modport slave (
    input  trigger, dist_out, dist_valid, err, err_code,
    output trig_suc, meas_valid, meas_dist
  );

endinterface

// File: rtl/sonic_ranger_ctrl_timer.sv
// ---------------------------------------------------------------------------
// sonic_timer
// Loadable down-counter shared by every state of the sequencer.
//   clk, rst_n  clock / asynchronous active-low reset
//   load        load 'value' this cycle (takes priority over counting)
//   value       reload value
//   done        high while the count equals 1, i.e. the last cycle of the
//               interval that was loaded
// The count parks at 0 instead of wrapping.
// ---------------------------------------------------------------------------
module sonic_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/sonic_ranger_ctrl.sv
// ---------------------------------------------------------------------------
// sonic_ranger_ctrl
// Upstream sequencer for the ultrasonic echo-width measurer. Fires the
// trigger, times out the measurer's trig_suc / meas_valid pulses, spaces
// shots apart and reports one distance or one error per shot.
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   start    single-shot request (only looked at in IDLE)
//   cont_en  level: back-to-back shots while high
//   busy     registered, high whenever the FSM is not in IDLE
//   bus      measurer link and result outputs (master modport)
// All outputs are registered from the next-state decode.
// ---------------------------------------------------------------------------
module sonic_ranger_ctrl
  import sonic_pkg::*;
#(
  parameter int DIST_W      = DEF_DIST_W,
  parameter int TRIG_CYC    = DEF_TRIG_CYC,
  parameter int ARM_TO_CYC  = DEF_ARM_TO_CYC,
  parameter int MEAS_TO_CYC = DEF_MEAS_TO_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cont_en,
  output logic               busy,
  sonic_ranger_ctrl_if.master bus
);

  localparam int MAX_CYC = max_of4(TRIG_CYC, ARM_TO_CYC, MEAS_TO_CYC, GAP_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  state_t            state, next_state;
  logic              tmr_load, tmr_done;
  logic [CNT_W-1:0]  tmr_value;
  logic              suc_seen;

  logic              trigger_q, dist_valid_q, err_q;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              dist_valid_d, err_d;

  sonic_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // Next-state / output decode. Every transition reloads the timer with the
  // length of the state being entered. Within a state, the measurer's pulse
  // is checked before the timeout so a pulse on the last cycle still counts.
  always_comb begin
    next_state   = state;
    tmr_load     = 1'b0;
    tmr_value    = '0;
    dist_d       = dist_q;
    dist_valid_d = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    case (state)
      IDLE: begin
        if (start || cont_en) begin
          next_state = TRIG;
          tmr_load   = 1'b1;
          tmr_value  = CNT_W'(TRIG_CYC);
        end
      end
      TRIG: begin
        // An early trig_suc is remembered; the trigger still runs full length.
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (suc_seen || bus.trig_suc) begin
            next_state = WAIT_MEAS;
            tmr_value  = CNT_W'(MEAS_TO_CYC);
          end else begin
            next_state = WAIT_ARM;
            tmr_value  = CNT_W'(ARM_TO_CYC - TRIG_CYC);
          end
        end
      end
      WAIT_ARM: begin
        if (bus.trig_suc) begin
          next_state = WAIT_MEAS;
          tmr_load   = 1'b1;
          tmr_value  = CNT_W'(MEAS_TO_CYC);
        end else if (tmr_done) begin
          next_state = GAP;
          tmr_load   = 1'b1;
          tmr_value  = CNT_W'(GAP_CYC);
          err_d      = 1'b1;
          err_code_d = ERR_ARM;
        end
      end
      WAIT_MEAS: begin
        if (bus.meas_valid) begin
          next_state   = GAP;
          tmr_load     = 1'b1;
          tmr_value    = CNT_W'(GAP_CYC);
          dist_d       = bus.meas_dist;
          dist_valid_d = 1'b1;
        end else if (tmr_done) begin
          next_state = GAP;
          tmr_load   = 1'b1;
          tmr_value  = CNT_W'(GAP_CYC);
          err_d      = 1'b1;
          err_code_d = ERR_MEAS;
        end
      end
      GAP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (cont_en) begin
            next_state = TRIG;
            tmr_value  = CNT_W'(TRIG_CYC);
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
        tmr_load   = 1'b1;
      end
    endcase
  end

  // State and registered outputs. trigger and busy come from the next state
  // so they line up with the state register; the async reset drops trigger
  // immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      trigger_q    <= 1'b0;
      busy         <= 1'b0;
      dist_q       <= '0;
      dist_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      suc_seen     <= 1'b0;
    end else begin
      state        <= next_state;
      trigger_q    <= (next_state == TRIG);
      busy         <= (next_state != IDLE);
      dist_q       <= dist_d;
      dist_valid_q <= dist_valid_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      // Only meaningful while in TRIG; clears itself on any other state.
      suc_seen     <= (state == TRIG) && (suc_seen || bus.trig_suc);
    end
  end

  assign bus.trigger    = trigger_q;
  assign bus.dist_out   = dist_q;
  assign bus.dist_valid = dist_valid_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_sonic_ranger_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sonic_ranger_ctrl
// Directed bench for sonic_ranger_ctrl with short cycle constants
// (TRIG=5, ARM=20, MEAS=50, GAP=30). Cycle c means "just after the c-th
// rising edge since the scenario began"; inputs set at cycle c are sampled
// at edge c+1. Expected cycle numbers are worked out by hand from the
// timing of each state.
// ---------------------------------------------------------------------------
module tb_sonic_ranger_ctrl;
  import sonic_pkg::*;

  localparam int DIST_W      = 17;
  localparam int TRIG_CYC    = 5;
  localparam int ARM_TO_CYC  = 20;
  localparam int MEAS_TO_CYC = 50;
  localparam int GAP_CYC     = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cont_en = 1'b0;
  logic busy;

  int n_vec = 0;
  int n_err = 0;

  // Observation record for the running scenario
  int                rise_q[$];
  int                dv_at_q[$];
  logic [DIST_W-1:0] dv_val_q[$];
  int                trig_hi, err_cnt, err_at, last_busy;
  logic              trig_prev;

  sonic_ranger_ctrl_if #(.DIST_W(DIST_W)) bus ();

  sonic_ranger_ctrl #(
    .DIST_W      (DIST_W),
    .TRIG_CYC    (TRIG_CYC),
    .ARM_TO_CYC  (ARM_TO_CYC),
    .MEAS_TO_CYC (MEAS_TO_CYC),
    .GAP_CYC     (GAP_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cont_en (cont_en),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    rise_q.delete();
    dv_at_q.delete();
    dv_val_q.delete();
    trig_hi   = 0;
    err_cnt   = 0;
    err_at    = -1;
    last_busy = -1;
    trig_prev = 1'b0;
  endtask

  task automatic observe(input int c);
    if (bus.trigger && !trig_prev) rise_q.push_back(c);
    if (bus.trigger) trig_hi++;
    trig_prev = bus.trigger;
    if (bus.dist_valid) begin
      dv_at_q.push_back(c);
      dv_val_q.push_back(bus.dist_out);
    end
    if (bus.err) begin
      err_cnt++;
      err_at = c;
    end
    if (busy) last_busy = c;
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (3) tick();
    n_vec++; if (bus.trigger !== 1'b0) begin n_err++; $display("[TB] FAIL rst_trigger: got %b want 0", bus.trigger); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (bus.dist_out !== '0) begin n_err++; $display("[TB] FAIL rst_dist: got %h want 0", bus.dist_out); end
    n_vec++; if (bus.dist_valid !== 1'b0 || bus.err !== 1'b0) begin n_err++; $display("[TB] FAIL rst_pulses: got dv=%b err=%b want 0 0", bus.dist_valid, bus.err); end
    n_vec++; if (bus.err_code !== ERR_NONE) begin n_err++; $display("[TB] FAIL rst_err_code: got %b want 00", bus.err_code); end
    start = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_shot();
    clear_stats();
    start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      tick();
      observe(c);
      start          = 1'b0;
      bus.trig_suc   = (c == 9);
      bus.meas_valid = (c == 29);
      bus.meas_dist  = (c == 29) ? 17'h00123 : 17'h1FFFF;
    end
    n_vec++; if (rise_q.size() !== 1 || rise_q[0] !== 1) begin n_err++; $display("[TB] FAIL single_rise: got n=%0d first=%0d want n=1 first=1", rise_q.size(), rise_q[0]); end
    n_vec++; if (trig_hi !== 5) begin n_err++; $display("[TB] FAIL single_trig_len: got %0d want 5", trig_hi); end
    n_vec++; if (dv_at_q.size() !== 1 || dv_at_q[0] !== 30) begin n_err++; $display("[TB] FAIL single_dv_at: got n=%0d at=%0d want n=1 at=30", dv_at_q.size(), dv_at_q[0]); end
    n_vec++; if (dv_val_q[0] !== 17'h00123) begin n_err++; $display("[TB] FAIL single_dist: got %h want 00123", dv_val_q[0]); end
    n_vec++; if (err_cnt !== 0) begin n_err++; $display("[TB] FAIL single_no_err: got %0d want 0", err_cnt); end
    n_vec++; if (last_busy !== 59) begin n_err++; $display("[TB] FAIL single_busy_end: got %0d want 59", last_busy); end
  endtask

  task automatic test_arm_timeout();
    clear_stats();
    start = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      tick();
      observe(c);
      start = 1'b0;
    end
    n_vec++; if (err_cnt !== 1 || err_at !== 21) begin n_err++; $display("[TB] FAIL arm_err_at: got n=%0d at=%0d want n=1 at=21", err_cnt, err_at); end
    n_vec++; if (bus.err_code !== ERR_ARM) begin n_err++; $display("[TB] FAIL arm_err_code: got %b want 01", bus.err_code); end
    n_vec++; if (dv_at_q.size() !== 0) begin n_err++; $display("[TB] FAIL arm_no_dv: got %0d want 0", dv_at_q.size()); end
    n_vec++; if (bus.dist_out !== 17'h00123) begin n_err++; $display("[TB] FAIL arm_dist_held: got %h want 00123", bus.dist_out); end
    n_vec++; if (last_busy !== 50) begin n_err++; $display("[TB] FAIL arm_busy_end: got %0d want 50", last_busy); end
  endtask

  task automatic test_meas_timeout();
    clear_stats();
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      observe(c);
      start          = 1'b0;
      bus.trig_suc   = (c == 9);
      bus.meas_valid = (c == 65);
      bus.meas_dist  = 17'h0ABCD;
    end
    n_vec++; if (err_cnt !== 1 || err_at !== 60) begin n_err++; $display("[TB] FAIL meas_err_at: got n=%0d at=%0d want n=1 at=60", err_cnt, err_at); end
    n_vec++; if (bus.err_code !== ERR_MEAS) begin n_err++; $display("[TB] FAIL meas_err_code: got %b want 10", bus.err_code); end
    n_vec++; if (dv_at_q.size() !== 0) begin n_err++; $display("[TB] FAIL meas_late_valid: got %0d dv want 0", dv_at_q.size()); end
    n_vec++; if (bus.dist_out !== 17'h00123) begin n_err++; $display("[TB] FAIL meas_dist_held: got %h want 00123", bus.dist_out); end
    n_vec++; if (last_busy !== 89) begin n_err++; $display("[TB] FAIL meas_busy_end: got %0d want 89", last_busy); end
  endtask

  task automatic test_early_suc();
    clear_stats();
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      observe(c);
      start          = 1'b0;
      bus.trig_suc   = (c == 3);
      bus.meas_valid = (c == 20);
      bus.meas_dist  = 17'h00777;
    end
    n_vec++; if (trig_hi !== 5) begin n_err++; $display("[TB] FAIL early_trig_len: got %0d want 5", trig_hi); end
    n_vec++; if (dv_at_q.size() !== 1 || dv_at_q[0] !== 21) begin n_err++; $display("[TB] FAIL early_dv_at: got n=%0d at=%0d want n=1 at=21", dv_at_q.size(), dv_at_q[0]); end
    n_vec++; if (bus.dist_out !== 17'h00777) begin n_err++; $display("[TB] FAIL early_dist: got %h want 00777", bus.dist_out); end
    n_vec++; if (last_busy !== 50) begin n_err++; $display("[TB] FAIL early_busy_end: got %0d want 50", last_busy); end
  endtask

  task automatic test_start_ignored();
    clear_stats();
    start = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      tick();
      observe(c);
      start          = (c == 20) || (c == 40);
      bus.trig_suc   = (c == 9);
      bus.meas_valid = (c == 29);
      bus.meas_dist  = 17'h00456;
    end
    start = 1'b0;
    n_vec++; if (rise_q.size() !== 1) begin n_err++; $display("[TB] FAIL ign_rises: got %0d want 1", rise_q.size()); end
    n_vec++; if (dv_at_q.size() !== 1 || dv_val_q[0] !== 17'h00456) begin n_err++; $display("[TB] FAIL ign_dist: got n=%0d val=%h want n=1 val=00456", dv_at_q.size(), dv_val_q[0]); end
    n_vec++; if (last_busy !== 59) begin n_err++; $display("[TB] FAIL ign_busy_end: got %0d want 59", last_busy); end
  endtask

  task automatic test_valid_on_timeout();
    clear_stats();
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      observe(c);
      start          = 1'b0;
      bus.trig_suc   = (c == 9);
      bus.meas_valid = (c == 59);
      bus.meas_dist  = 17'h1ABCD;
    end
    n_vec++; if (dv_at_q.size() !== 1 || dv_at_q[0] !== 60) begin n_err++; $display("[TB] FAIL edge_dv_at: got n=%0d at=%0d want n=1 at=60", dv_at_q.size(), dv_at_q[0]); end
    n_vec++; if (bus.dist_out !== 17'h1ABCD) begin n_err++; $display("[TB] FAIL edge_dist: got %h want 1abcd", bus.dist_out); end
    n_vec++; if (err_cnt !== 0) begin n_err++; $display("[TB] FAIL edge_no_err: got %0d want 0", err_cnt); end
    n_vec++; if (bus.err_code !== ERR_MEAS) begin n_err++; $display("[TB] FAIL edge_code_held: got %b want 10", bus.err_code); end
  endtask

  // Measurer responder: trig_suc 8 cycles and meas_valid 28 cycles after each
  // observed trigger rise; cont_en is dropped at drop_at.
  task automatic run_cont(input int ncyc, input int drop_at);
    int r;
    clear_stats();
    cont_en = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      observe(c);
      if (c == drop_at) cont_en = 1'b0;
      r = (rise_q.size() > 0) ? rise_q[rise_q.size()-1] : -100;
      bus.trig_suc   = (c == r + 8);
      bus.meas_valid = (c == r + 28);
      bus.meas_dist  = 17'h00010 + 17'(rise_q.size() - 1);
    end
    cont_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_cont(200, 130);
    n_vec++; if (rise_q.size() !== 3 || rise_q[1] !== 60 || rise_q[2] !== 119) begin n_err++; $display("[TB] FAIL cont_rises: got n=%0d r1=%0d r2=%0d want n=3 r1=60 r2=119", rise_q.size(), rise_q[1], rise_q[2]); end
    n_vec++; if (dv_at_q.size() !== 3) begin n_err++; $display("[TB] FAIL cont_dv_count: got %0d want 3", dv_at_q.size()); end
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (dv_at_q[k] !== 30 + 59*k || dv_val_q[k] !== 17'(16 + k)) begin n_err++; $display("[TB] FAIL cont_shot%0d: got at=%0d val=%h want at=%0d val=%h", k, dv_at_q[k], dv_val_q[k], 30 + 59*k, 17'(16 + k)); end
    end
    n_vec++; if (last_busy !== 177) begin n_err++; $display("[TB] FAIL cont_busy_end: got %0d want 177", last_busy); end
  endtask

  task automatic test_cont_drop();
    run_cont(150, 70);
    n_vec++; if (rise_q.size() !== 2) begin n_err++; $display("[TB] FAIL drop_rises: got %0d want 2", rise_q.size()); end
    n_vec++; if (dv_at_q.size() !== 2 || dv_at_q[1] !== 89) begin n_err++; $display("[TB] FAIL drop_results: got n=%0d at=%0d want n=2 at=89", dv_at_q.size(), dv_at_q[1]); end
    n_vec++; if (last_busy !== 118 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL drop_idle: got last=%0d busy=%b want last=118 busy=0", last_busy, busy); end
  endtask

  task automatic test_reset_in_trig();
    start = 1'b1;
    repeat (3) begin
      tick();
      start = 1'b0;
    end
    n_vec++; if (bus.trigger !== 1'b1) begin n_err++; $display("[TB] FAIL rtrig_pre: got %b want 1", bus.trigger); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.trigger !== 1'b0 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL rtrig_async: got trig=%b busy=%b want 0 0", bus.trigger, busy); end
    n_vec++; if (bus.dist_out !== '0 || bus.err_code !== ERR_NONE) begin n_err++; $display("[TB] FAIL rtrig_regs: got dist=%h code=%b want 0 00", bus.dist_out, bus.err_code); end
    n_vec++; if (bus.dist_valid !== 1'b0 || bus.err !== 1'b0) begin n_err++; $display("[TB] FAIL rtrig_pulses: got dv=%b err=%b want 0 0", bus.dist_valid, bus.err); end
    #2 rst_n = 1'b1;
    clear_stats();
    for (int c = 1; c <= 20; c++) begin
      tick();
      observe(c);
    end
    n_vec++; if (trig_hi !== 0 || last_busy !== -1) begin n_err++; $display("[TB] FAIL rtrig_idle_after: got trig=%0d busy_last=%0d want 0 -1", trig_hi, last_busy); end
  endtask

  initial begin
    bus.trig_suc   = 1'b0;
    bus.meas_valid = 1'b0;
    bus.meas_dist  = '0;
    test_reset();
    test_single_shot();
    test_arm_timeout();
    test_meas_timeout();
    test_early_suc();
    test_start_ignored();
    test_valid_on_timeout();
    test_back_to_back();
    test_cont_drop();
    test_reset_in_trig();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
